// File: rtl/tc_timer.sv
// tc_timer: memory-mapped down-counting timer with one-shot and
// auto-reload modes and a maskable interrupt output.
//
// Register map (addr[3:2]):
//   00 CTRL   : bit0 EN, bits2:1 MODE (01 = auto-reload, else one-shot),
//               bit3 IM (irq mask); upper bits read 0
//   01 PRESET : 32-bit read/write, byte-lane writable
//   10 COUNT  : 32-bit read-only
//   11        : reads 0, writes ignored
//
// Bus handshake: there is no valid/ready pair on this port. A store is a
// single-cycle 'we' pulse that is always accepted at the edge where it is
// sampled; a load is a combinational read of 'rdata' for the current 'addr'.
//
// The FSM state is exported on dbg_state (0 IDLE, 1 LOAD, 2 CNT, 3 INT).
module tc_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic [3:0]  byteen,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq,
   output logic [1:0]  dbg_state
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_CNT  = 2'd2;
   localparam logic [1:0] S_INT  = 2'd3;

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_PRESET = 2'd1;
   localparam logic [1:0] A_COUNT  = 2'd2;

   logic [1:0]  state;
   logic [3:0]  ctrl;
   logic [31:0] preset;
   logic [31:0] count;
   logic        irq_flag;

   logic        ctrl_wr;
   logic        preset_wr;
   logic        auto_reload;
   logic        unused_addr_bits;

   assign ctrl_wr     = we && (addr[3:2] == A_CTRL);
   assign preset_wr   = we && (addr[3:2] == A_PRESET);
   // MODE 1x falls back to one-shot, so only the exact 01 pattern reloads.
   assign auto_reload = (ctrl[2:1] == 2'b01);

   // Only addr[3:2] is decoded; the bridge already qualified the window.
   assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

   // FSM and register file; bus writes are applied after the FSM so a CTRL
   // write wins over the FSM's own EN-clear in INT and clears irq_flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         ctrl     <= 4'd0;
         preset   <= 32'd0;
         count    <= 32'd0;
         irq_flag <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (ctrl[0]) state <= S_LOAD;
            end
            S_LOAD: begin
               count <= preset;
               state <= S_CNT;
            end
            S_CNT: begin
               if (!ctrl[0]) begin
                  // Disabled mid-count: COUNT is held, next enable reloads.
                  state <= S_IDLE;
               end else if (count > 32'd1) begin
                  count <= count - 32'd1;
               end else begin
                  // count of 0 or 1 both expire here, so PRESET=0 acts as 1.
                  count    <= 32'd0;
                  irq_flag <= 1'b1;
                  state    <= S_INT;
               end
            end
            S_INT: begin
               state <= S_IDLE;
               if (auto_reload) irq_flag <= 1'b0;
               else             ctrl[0]  <= 1'b0;
            end
         endcase

         if (ctrl_wr) begin
            if (byteen[0]) ctrl <= wdata[3:0];
            irq_flag <= 1'b0;
         end

         if (preset_wr) begin
            for (int i = 0; i < 4; i++) begin
               if (byteen[i]) preset[8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   // Zero-latency read mux over the current register contents.
   always_comb begin
      rdata = 32'd0;
      case (addr[3:2])
         A_CTRL:   rdata = {28'd0, ctrl};
         A_PRESET: rdata = preset;
         A_COUNT:  rdata = count;
         default:  rdata = 32'd0;
      endcase
   end

   assign irq       = ctrl[3] & irq_flag;
   assign dbg_state = state;

endmodule

// File: tb/tb_tc_timer.sv
// tb_tc_timer: directed scenarios followed by randomized bus traffic, all
// checked against a timeline model of the timer. The model tracks the edge
// at which a run left idle and derives COUNT, expiry and return-to-idle
// from elapsed edges rather than from a state register.
module tb_tc_timer;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  byteen;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;
   logic [1:0]  dbg_state;

   always #10 clk = ~clk;

   tc_timer dut (
      .clk       (clk),
      .reset     (reset),
      .addr      (addr),
      .we        (we),
      .byteen    (byteen),
      .wdata     (wdata),
      .rdata     (rdata),
      .irq       (irq),
      .dbg_state (dbg_state)
   );

   int tests_run = 0;
   int tests_failed = 0;

   // ---------------- reference model ----------------
   logic [3:0]  m_ctrl;
   logic [31:0] m_preset;
   logic [31:0] m_count;
   logic        m_flag;
   bit          m_run;      // a run is in progress (not idle)
   longint      m_le;       // edge number at which the run entered LOAD
   longint      m_n;        // PRESET value captured by the run
   longint      edge_no = 0;

   function automatic logic [31:0] model_read(input logic [31:0] a);
      case (a[3:2])
         2'd0:    return {28'd0, m_ctrl};
         2'd1:    return m_preset;
         2'd2:    return m_count;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic model_irq();
      return m_ctrl[3] & m_flag;
   endfunction

   // Advance the model by one rising edge with the inputs sampled there.
   task automatic model_step(input logic r, input logic w, input logic [31:0] a,
                             input logic [3:0] be, input logic [31:0] d);
      logic [3:0]  n_ctrl;
      logic [31:0] n_count;
      logic        n_flag;
      logic        old_en;
      logic        is_auto;
      longint      el;
      longint      n1;
      edge_no++;
      if (r) begin
         m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0;
         m_run = 1'b0;
         return;
      end
      n_ctrl  = m_ctrl;
      n_count = m_count;
      n_flag  = m_flag;
      old_en  = m_ctrl[0];
      is_auto = (m_ctrl[2:1] == 2'b01);
      if (!m_run) begin
         if (old_en) begin
            m_run = 1'b1;
            m_le  = edge_no;
         end
      end else begin
         el = edge_no - m_le;
         if (el == 1) begin
            m_n     = longint'(m_preset);
            n_count = m_preset;
         end else begin
            n1 = (m_n < 1) ? 1 : m_n;
            if (el <= n1 + 1) begin
               if (!old_en) begin
                  m_run = 1'b0;
               end else if (el <= n1) begin
                  n_count = 32'(m_n - (el - 1));
               end else begin
                  n_count = 32'd0;
                  n_flag  = 1'b1;
               end
            end else begin
               m_run = 1'b0;
               if (is_auto) n_flag = 1'b0;
               else         n_ctrl[0] = 1'b0;
            end
         end
      end
      if (w && a[3:2] == 2'd0) begin
         if (be[0]) n_ctrl = d[3:0];
         n_flag = 1'b0;
      end
      if (w && a[3:2] == 2'd1) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) m_preset[8*i +: 8] = d[8*i +: 8];
      end
      m_ctrl  = n_ctrl;
      m_count = n_count;
      m_flag  = n_flag;
   endtask

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Drive one edge worth of inputs; check outputs against the model
   // before the edge, then advance the model at the edge.
   task automatic cycle(input logic r, input logic w, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] d);
      reset = r; we = w; addr = a; byteen = be; wdata = d;
      #1;
      check("rdata_model", rdata, model_read(a));
      check("irq_model", {31'd0, irq}, {31'd0, model_irq()});
      check("idle_model", {31'd0, dbg_state == 2'd0}, {31'd0, !m_run});
      @(posedge clk);
      model_step(r, w, a, be, d);
      #1;
   endtask

   task automatic idle();
      logic [31:0] a;
      a = $urandom;
      cycle(1'b0, 1'b0, a, 4'h0, 32'd0);
   endtask

   task automatic wr(input logic [3:0] sel, input logic [3:0] be, input logic [31:0] d);
      cycle(1'b0, 1'b1, {28'd0, sel[1:0], 2'b00}, be, d);
   endtask

   // Combinational read between edges against a bench-computed constant.
   task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string tag);
      we = 1'b0; addr = a;
      #1;
      check(tag, rdata, exp);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] held;
      reset = 1'b1; we = 1'b0; addr = 32'd0; byteen = 4'h0; wdata = 32'd0;
      repeat (2) @(posedge clk);
      model_step(1'b1, 1'b0, 32'd0, 4'h0, 32'd0);
      #1;

      // Reset state: every address reads 0, irq low.
      cycle(1'b1, 1'b0, 32'd0, 4'h0, 32'd0);
      peek(32'h0, 32'd0, "rst_ctrl");
      peek(32'h4, 32'd0, "rst_preset");
      peek(32'h8, 32'd0, "rst_count");
      peek(32'hC, 32'd0, "rst_rsvd");
      check("rst_irq", {31'd0, irq}, 32'd0);

      // One-shot, PRESET=5.
      wr(4'd1, 4'hF, 32'd5);
      wr(4'd0, 4'hF, 32'h9);                  // E0
      idle();                                 // E1
      for (int v = 5; v >= 1; v--) begin      // E2..E6
         idle();
         exp_q.push_back(32'(v));
         peek(32'h8, exp_q.pop_front(), "os_count");
      end
      check("os_irq_pre", {31'd0, irq}, 32'd0);
      idle();                                 // E7
      peek(32'h8, 32'd0, "os_count_zero");
      check("os_irq_rise", {31'd0, irq}, 32'd1);
      idle();                                 // E8
      peek(32'h0, 32'h8, "os_ctrl_en_clr");
      repeat (3) idle();
      check("os_irq_sticky", {31'd0, irq}, 32'd1);
      wr(4'd0, 4'hF, 32'h8);
      check("os_irq_clear", {31'd0, irq}, 32'd0);

      // Auto-reload, PRESET=3: pulses after E5, E11, E17.
      wr(4'd1, 4'hF, 32'd3);
      wr(4'd0, 4'hF, 32'hB);                  // E0
      for (int k = 1; k <= 18; k++) begin
         idle();
         check("ar_irq", {31'd0, irq}, {31'd0, (k == 5 || k == 11 || k == 17)});
         if (k == 2 || k == 8 || k == 14) peek(32'h8, 32'd3, "ar_reload");
      end
      wr(4'd0, 4'hF, 32'h0);
      repeat (2) idle();

      // Byte-lane PRESET write and ignored COUNT write.
      wr(4'd1, 4'hF, 32'h1122_3344);
      wr(4'd1, 4'b0010, 32'hAABB_CCDD);
      peek(32'h4, 32'h1122_CC44, "lane_write");
      held = m_count;
      wr(4'd2, 4'hF, 32'hDEAD_BEEF);
      peek(32'h8, held, "count_ro");
      wr(4'd3, 4'hF, 32'hDEAD_BEEF);
      peek(32'hC, 32'd0, "rsvd_ro");

      // Disable mid-count holds COUNT; re-enable reloads.
      wr(4'd1, 4'hF, 32'd10);
      wr(4'd0, 4'hF, 32'h9);                  // E0
      repeat (5) idle();                      // E1..E5, COUNT=7
      peek(32'h8, 32'd7, "dis_pre");
      wr(4'd0, 4'hF, 32'h8);                  // E6, COUNT=6
      idle();                                 // E7, FSM sees EN=0
      peek(32'h8, 32'd6, "dis_hold");
      check("dis_idle", {30'd0, dbg_state}, 32'd0);
      repeat (3) idle();
      peek(32'h8, 32'd6, "dis_hold_late");
      check("dis_no_irq", {31'd0, irq}, 32'd0);
      wr(4'd0, 4'hF, 32'h9);
      repeat (2) idle();
      peek(32'h8, 32'd10, "reen_reload");
      wr(4'd0, 4'hF, 32'h0);
      repeat (2) idle();

      // Reset overrides a concurrent CTRL write and aborts the count.
      wr(4'd1, 4'hF, 32'd4);
      wr(4'd0, 4'hF, 32'h9);
      repeat (3) idle();
      cycle(1'b1, 1'b1, 32'h0, 4'hF, 32'h9);
      peek(32'h0, 32'd0, "rstw_ctrl");
      peek(32'h8, 32'd0, "rstw_count");
      check("rstw_irq", {31'd0, irq}, 32'd0);
      repeat (4) idle();
      peek(32'h8, 32'd0, "rstw_quiet");

      // PRESET=0 behaves like 1.
      wr(4'd1, 4'hF, 32'd0);
      wr(4'd0, 4'hF, 32'h9);                  // E0
      repeat (3) idle();                      // E3 = N+2 with N=1
      check("p0_irq", {31'd0, irq}, 32'd1);
      wr(4'd0, 4'hF, 32'h0);

      // Randomized traffic against the model.
      for (int n = 0; n < 2000; n++) begin
         logic [31:0] a;
         logic [31:0] d;
         logic [3:0]  be;
         logic [3:0]  bits;
         logic        w;
         logic        r;
         a  = $urandom;
         r  = ($urandom_range(0, 99) == 0);
         w  = ($urandom_range(0, 5) == 0);
         be = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         d  = $urandom;
         if (a[3:2] == 2'd0) begin
            bits = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) bits[0] = 1'b1;
            d = (d & 32'hFFFF_FFF0) | {28'd0, bits};
         end else if (a[3:2] == 2'd1) begin
            d = 32'($urandom_range(0, 9));
         end
         cycle(r, w, a, be, d);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/tc_timer.md
# tc_timer

Memory-mapped timer/counter peripheral: the responder on the CPU data bus (address, write data, byte enables, read data) and a source of one `HWInt` line. The system bridge decodes a 16-byte window, asserts `we` for stores to it, and returns `rdata` for loads. The block counts down a programmed preset and raises `irq` on expiry, in either one-shot or auto-reload mode.

## Interface
- Parameters: none.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high; clears all state.
- `addr` input 32: byte address from CPU; only `addr[3:2]` is decoded.
- `we` input 1: write strobe from bridge; valid only for the current cycle.
- `byteen` input 4: byte-lane enables for the write; lane i covers `wdata[8i+7:8i]`.
- `wdata` input 32: write data.
- `rdata` output 32: read data for `addr`; combinational.
- `irq` output 1: interrupt request to `HWInt`; registered.

## Operation
- Register map by `addr[3:2]`:
  - 00 CTRL: bit0 EN, bits2:1 MODE (00 one-shot, 01 auto-reload; 1x treated as one-shot), bit3 IM (irq mask). Other bits read 0.
  - 01 PRESET: 32-bit, read/write.
  - 10 COUNT: 32-bit, read-only; writes ignored.
  - 11: reads 0, writes ignored.
- Writes apply per byte lane. CTRL updates only from lane 0 (`byteen[0]`), bits 3:0.
- Internal `irq_flag`; `irq = IM & irq_flag`.
- FSM states:
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if !EN, go to IDLE with COUNT held. Else if COUNT > 1, COUNT <= COUNT-1. Else COUNT <= 0, `irq_flag` <= 1, go to INT.
  - INT: go to IDLE.
    - One-shot: EN <= 0; `irq_flag` stays high.
    - Auto-reload: EN stays; `irq_flag` <= 0, giving a one-cycle pulse.
- Any CTRL write clears `irq_flag`.
- Re-enabling after a disable reloads from PRESET; there is no resume.
- Simultaneous CTRL write and FSM EN-clear in INT: the written value wins.
- A PRESET write during counting does not affect COUNT until the next LOAD.
- PRESET = 0 behaves like PRESET = 1, except COUNT reads 0 during CNT.
- Reset clears CTRL, PRESET, COUNT, and `irq_flag`, and sets state to IDLE. It overrides a concurrent write and aborts any count in progress.

## Timing
- Reset values: `irq` = 0. `rdata` = 0 for every address.
- Register writes take effect at the edge where `we` is sampled; read-back is visible the next cycle.
- `rdata` has zero-cycle latency and reflects the current register contents.
- Edge E0 writes EN=1 (state IDLE). Then, with PRESET = N ≥ 1:
  - E1: state LOAD.
  - E2: COUNT = N, state CNT.
  - E2+k: COUNT = N−k, for k ≤ N−1.
  - E(N+2): COUNT = 0, state INT, `irq_flag` = 1.
  - E(N+3): state IDLE. One-shot: EN = 0. Auto-reload: `irq_flag` = 0.
  - E(N+4), auto-reload only: LOAD again.
- Auto-reload period is N+3 cycles; `irq` is high for exactly 1 cycle per period.
- One-shot `irq` stays high until a CTRL write or reset.

## Test plan
- Reset, then read all four addresses → `rdata` = 0 for each; `irq` = 0.
- PRESET=5 with all byte enables, then CTRL=0x9 (EN, one-shot, IM) → COUNT reads 5,4,3,2,1 on successive cycles, then 0. `irq` rises at E7 and stays high. CTRL reads 0x8 after E8. Writing CTRL=0x8 drops `irq` the next cycle.
- PRESET=3, CTRL=0xB (auto-reload, IM) → `irq` is one-cycle pulses every 6 cycles (first at E5); COUNT reloads to 3.
- PRESET write with `byteen`=0010 and `wdata`=0xAABBCCDD onto 0x11223344 → reads 0x1122CC44. A COUNT write → COUNT unchanged.
- Enable with PRESET=10. At COUNT=6, write CTRL=0x8 → COUNT holds 6, state IDLE, no irq. Re-enable → COUNT reloads to 10.
- PRESET=4, counting. Assert `reset` with `we`=1 writing CTRL=0x9 → next cycle CTRL=0, COUNT=0, `irq`=0, no count activity.
